// File: rtl/gray_ptr_sync_multi.sv
// gray_ptr_sync_multi: multi-stage gray pointer + flag synchroniser with registered binary pointer and update pulse (optional step check under GRAY_SYNC_CHECK_EN)
module gray_ptr_sync_multi #(
  parameter int AWIDTH = 3,
  parameter int SYNC_STAGES = 2,
  parameter int FLAG_CNT = 1,
  parameter logic [FLAG_CNT-1:0] FLAG_RST = '0
) (
  input  logic                clk_i,
  input  logic                srst_i,
  input  logic [AWIDTH:0]     pntr_gray_i,
  input  logic [FLAG_CNT-1:0] flag_i,
  output logic [AWIDTH:0]     pntr_gray_o,
  output logic [AWIDTH:0]     pntr_bin_o,
  output logic                pntr_upd_o,
  output logic [FLAG_CNT-1:0] flag_o,
  output logic                gray_err_o
);
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("gray_ptr_sync_multi: SYNC_STAGES must be in 2..4");
  end
  logic [SYNC_STAGES-1:0][AWIDTH:0]   ptr_q;
  logic [SYNC_STAGES-1:0][FLAG_CNT-1:0] flag_q;
  logic [AWIDTH:0] bin_q, bin_d;
  logic            upd_q, upd_d;
  assign pntr_gray_o = ptr_q[SYNC_STAGES-1];
  assign flag_o      = flag_q[SYNC_STAGES-1];
  assign pntr_bin_o  = bin_q;
  assign pntr_upd_o  = upd_q;
  // gray->binary: each binary bit is the xor of all gray bits at or above it
  always_comb begin
    bin_d = '0;
    for (int i = 0; i <= AWIDTH; i++) bin_d[i] = ^(pntr_gray_o >> i);
    upd_d = bin_d != bin_q;
  end
  // synchroniser chains; first stage takes the raw input with only the reset mux in front
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ptr_q  <= '0;
      flag_q <= {SYNC_STAGES{FLAG_RST}};
      bin_q  <= '0;
      upd_q  <= 1'b0;
    end else begin
      ptr_q  <= {ptr_q[SYNC_STAGES-2:0], pntr_gray_i};
      flag_q <= {flag_q[SYNC_STAGES-2:0], flag_i};
      bin_q  <= bin_d;
      upd_q  <= upd_d;
    end
  end
`ifdef GRAY_SYNC_CHECK_EN
  logic [AWIDTH:0] prev_q;
  logic            chk_q, err_q, err_d;
  assign err_d      = err_q | (chk_q & ($countones(pntr_gray_o ^ prev_q) > 1));
  assign gray_err_o = err_q;
  // sticky flag for synchronised pointer moving more than one bit; first edge after reset skipped
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      prev_q <= '0;
      chk_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= pntr_gray_o;
      chk_q  <= 1'b1;
      err_q  <= err_d;
    end
  end
`else
  assign gray_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_gray_ptr_sync_multi.sv
// tb_gray_ptr_sync_multi: randomized and directed checks against a queue-based reference model
module tb_gray_ptr_sync_multi;
  localparam int AW = 3;
  localparam int S = 3;
  localparam int FC = 4;
  localparam logic [FC-1:0] FRST = 4'b0110;
`ifdef GRAY_SYNC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0;
  logic srst;
  logic [AW:0] pntr_in;
  logic [FC-1:0] flag_in;
  logic [AW:0] gray_o, bin_o;
  logic upd_o, err_o;
  logic [FC-1:0] flag_o;
  int checks = 0;
  int failures = 0;
  gray_ptr_sync_multi #(.AWIDTH(AW), .SYNC_STAGES(S), .FLAG_CNT(FC), .FLAG_RST(FRST)) dut (
    .clk_i(clk), .srst_i(srst), .pntr_gray_i(pntr_in), .flag_i(flag_in),
    .pntr_gray_o(gray_o), .pntr_bin_o(bin_o), .pntr_upd_o(upd_o),
    .flag_o(flag_o), .gray_err_o(err_o));
  always #5 clk = ~clk;
  logic [AW:0] m_pipe[$];
  logic [FC-1:0] m_fpipe[$];
  logic [AW:0] m_gray, m_bin, m_prev;
  logic [FC-1:0] m_flag;
  logic m_upd, m_err, m_first;
  function automatic logic [AW:0] g2b(input logic [AW:0] g);
    logic [AW:0] b;
    b = '0;
    for (int i = 0; i <= AW; i++) b = b ^ (g >> i);
    return b;
  endfunction
  function automatic logic [AW:0] b2g(input int v);
    logic [AW:0] b;
    b = v[AW:0];
    return b ^ (b >> 1);
  endfunction
  task automatic tick();
    logic [AW:0] nb;
    @(posedge clk);
    if (srst) begin
      m_pipe = {};
      m_fpipe = {};
      for (int i = 0; i < S; i++) begin
        m_pipe.push_back('0);
        m_fpipe.push_back(FRST);
      end
      m_gray = '0; m_bin = '0; m_prev = '0; m_flag = FRST;
      m_upd = 1'b0; m_err = 1'b0; m_first = 1'b1;
    end else begin
      nb = g2b(m_gray);
      if (CHK && !m_first && $countones(m_gray ^ m_prev) > 1) m_err = 1'b1;
      m_prev = m_gray;
      m_first = 1'b0;
      m_upd = nb != m_bin;
      m_bin = nb;
      m_pipe.push_back(pntr_in);
      void'(m_pipe.pop_front());
      m_gray = m_pipe[0];
      m_fpipe.push_back(flag_in);
      void'(m_fpipe.pop_front());
      m_flag = m_fpipe[0];
    end
    #1;
  endtask
  task automatic test_reset();
    srst = 1'b1;
    pntr_in = 4'b0101;
    flag_in = 4'b1001;
    repeat (3) tick();
    checks += 5;
    if (gray_o !== 4'b0000) begin failures++; $display("FAIL reset_gray got=%b exp=0000", gray_o); end
    if (bin_o !== 4'd0) begin failures++; $display("FAIL reset_bin got=%0d exp=0", bin_o); end
    if (flag_o !== FRST) begin failures++; $display("FAIL reset_flag got=%b exp=%b", flag_o, FRST); end
    if (upd_o !== 1'b0) begin failures++; $display("FAIL reset_upd got=%b exp=0", upd_o); end
    if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_o); end
  endtask
  task automatic test_latency();
    srst = 1'b0;
    pntr_in = '0;
    flag_in = FRST;
    repeat (S + 2) tick();
    pntr_in = 4'b0001;
    for (int e = 1; e <= S + 2; e++) begin
      tick();
      checks += 3;
      if (gray_o !== (e >= S ? 4'b0001 : 4'b0000)) begin failures++; $display("FAIL lat_gray edge=%0d got=%b", e, gray_o); end
      if (bin_o !== (e >= S + 1 ? 4'd1 : 4'd0)) begin failures++; $display("FAIL lat_bin edge=%0d got=%0d", e, bin_o); end
      if (upd_o !== (e == S + 1)) begin failures++; $display("FAIL lat_upd edge=%0d got=%b", e, upd_o); end
    end
  endtask
  task automatic test_wrap();
    int pulses;
    int nxt;
    srst = 1'b1;
    pntr_in = '0;
    tick();
    srst = 1'b0;
    tick();
    pulses = 0;
    nxt = 1;
    for (int c = 1; c <= 16 + S + 3; c++) begin
      if (c <= 16) pntr_in = b2g(c % 16);
      tick();
      if (upd_o) begin
        pulses++;
        checks++;
        if (bin_o !== 4'(nxt % 16)) begin failures++; $display("FAIL wrap_seq got=%0d exp=%0d", bin_o, nxt % 16); end
        nxt++;
      end
      checks++;
      if (bin_o !== m_bin) begin failures++; $display("FAIL wrap_model got=%0d exp=%0d", bin_o, m_bin); end
    end
    checks += 3;
    if (pulses != 16) begin failures++; $display("FAIL wrap_pulses got=%0d exp=16", pulses); end
    if (bin_o !== 4'd0) begin failures++; $display("FAIL wrap_end got=%0d exp=0", bin_o); end
    if (err_o !== 1'b0) begin failures++; $display("FAIL wrap_err got=%b exp=0", err_o); end
  endtask
  task automatic test_multibit();
    srst = 1'b1;
    pntr_in = '0;
    tick();
    srst = 1'b0;
    pntr_in = 4'b0011;
    for (int e = 1; e <= S + 4; e++) begin
      tick();
      checks++;
      if (err_o !== (CHK && e >= S + 1)) begin failures++; $display("FAIL multibit_err edge=%0d got=%b exp=%b", e, err_o, CHK && e >= S + 1); end
    end
    srst = 1'b1;
    tick();
    srst = 1'b0;
    checks++;
    if (err_o !== 1'b0) begin failures++; $display("FAIL multibit_clear got=%b exp=0", err_o); end
  endtask
  task automatic test_reset_midflight();
    pntr_in = '0;
    repeat (S + 2) tick();
    pntr_in = 4'b0001;
    tick();
    srst = 1'b1;
    pntr_in = '0;
    tick();
    srst = 1'b0;
    for (int e = 0; e < S + 3; e++) begin
      tick();
      checks += 3;
      if (upd_o !== 1'b0) begin failures++; $display("FAIL mid_upd edge=%0d got=%b exp=0", e, upd_o); end
      if (gray_o !== 4'b0000) begin failures++; $display("FAIL mid_gray edge=%0d got=%b exp=0000", e, gray_o); end
      if (bin_o !== 4'd0) begin failures++; $display("FAIL mid_bin edge=%0d got=%0d exp=0", e, bin_o); end
    end
  endtask
  task automatic test_flags();
    logic [AW:0] g0, b0;
    flag_in = 4'b0000;
    pntr_in = 4'b0110;
    repeat (S + 3) tick();
    g0 = gray_o;
    b0 = bin_o;
    flag_in = 4'b1010;
    for (int e = 1; e <= S + 1; e++) begin
      tick();
      checks += 3;
      if (flag_o !== (e >= S ? 4'b1010 : 4'b0000)) begin failures++; $display("FAIL flag_lat edge=%0d got=%b", e, flag_o); end
      if (gray_o !== g0) begin failures++; $display("FAIL flag_gray got=%b exp=%b", gray_o, g0); end
      if (bin_o !== b0) begin failures++; $display("FAIL flag_bin got=%0d exp=%0d", bin_o, b0); end
    end
  endtask
  task automatic test_random();
    int cnt;
    int hold;
    cnt = 0;
    hold = 0;
    srst = 1'b1;
    tick();
    srst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      srst = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 9) == 0) cnt = $urandom_range(0, 15);
      else if ($urandom_range(0, 2) != 0) cnt = (cnt + 1) % 16;
      pntr_in = b2g(cnt);
      if (hold == 0) begin
        flag_in = FC'($urandom);
        hold = S + 1 + $urandom_range(0, 3);
      end else hold--;
      tick();
      checks += 6;
      if (gray_o !== m_gray) begin failures++; $display("FAIL rnd_gray cyc=%0d got=%b exp=%b", c, gray_o, m_gray); end
      if (bin_o !== m_bin) begin failures++; $display("FAIL rnd_bin cyc=%0d got=%0d exp=%0d", c, bin_o, m_bin); end
      if (upd_o !== m_upd) begin failures++; $display("FAIL rnd_upd cyc=%0d got=%b exp=%b", c, upd_o, m_upd); end
      if (flag_o !== m_flag) begin failures++; $display("FAIL rnd_flag cyc=%0d got=%b exp=%b", c, flag_o, m_flag); end
      if (err_o !== m_err) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", c, err_o, m_err); end
      if (bin_o !== g2b(gray_o) && !upd_o && m_bin == g2b(m_gray)) begin failures++; $display("FAIL rnd_conv cyc=%0d gray=%b bin=%0d", c, gray_o, bin_o); end
    end
    srst = 1'b0;
  endtask
  initial begin
    srst = 1'b1;
    pntr_in = '0;
    flag_in = '0;
    #2;
    test_reset();
    test_latency();
    test_wrap();
    test_multibit();
    test_reset_midflight();
    test_flags();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
